pdm_capture: RTL

PDM_CAPTURE -- requirements
Module: pdm_capture

---
 rtl/pdm_capture.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pdm_capture.sv
// Stereo PDM microphone front end: generates the mic clock, captures the
// shared data line on both phases and reports per-frame ones-counts for the
// left and right channels through a valid/ready holding register.
module pdm_capture #(
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEC   = 64,
  parameter int unsigned OUT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pdm_data,
  output logic             pdm_clk,
  output logic [OUT_W-1:0] pcm_left,
  output logic [OUT_W-1:0] pcm_right,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun
);

  localparam int unsigned      HC_W    = $clog2(DIV);
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(DIV - 1);
  localparam logic [OUT_W-1:0] FC_LAST = OUT_W'(DEC - 1);

  logic [1:0]       sync_q;
  logic [HC_W-1:0]  hc;
  logic [OUT_W-1:0] fc;
  logic [OUT_W-1:0] acc_l;
  logic [OUT_W-1:0] acc_r;

  logic             bit_c;
  logic             tick_c;
  logic             cap_l_c;
  logic             cap_r_c;
  logic             complete_c;
  logic [OUT_W-1:0] sum_l_c;
  logic [OUT_W-1:0] sum_r_c;

  assign bit_c = sync_q[1];

  // Capture strobes: a capture happens on the last count of each half period;
  // the bit goes to left while pdm_clk is high, to right while it is low.
  always_comb begin
    tick_c     = 1'b0;
    cap_l_c    = 1'b0;
    cap_r_c    = 1'b0;
    complete_c = 1'b0;
    sum_l_c    = acc_l + OUT_W'(bit_c);
    sum_r_c    = acc_r + OUT_W'(bit_c);
    if (enable && (hc == HC_LAST)) begin
      tick_c     = 1'b1;
      cap_l_c    = pdm_clk;
      cap_r_c    = ~pdm_clk;
      complete_c = ~pdm_clk && (fc == FC_LAST);
    end
  end

  // Two-flop synchronizer for the asynchronous data line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pdm_data};
    end
  end

  // Clock divider, frame counter and channel accumulators; disabling drops any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc      <= '0;
      pdm_clk <= 1'b0;
      fc      <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
    end else if (!enable) begin
      hc      <= '0;
      pdm_clk <= 1'b0;
      fc      <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
    end else if (tick_c) begin
      hc      <= '0;
      pdm_clk <= ~pdm_clk;
      if (cap_l_c) begin
        acc_l <= sum_l_c;
      end else if (complete_c) begin
        fc    <= '0;
        acc_l <= '0;
        acc_r <= '0;
      end else if (cap_r_c) begin
        fc    <= fc + OUT_W'(1);
        acc_r <= sum_r_c;
      end
    end else begin
      hc <= hc + HC_W'(1);
    end
  end

  // Output holding register: load a finished frame when free or being accepted, else drop it and flag overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcm_left  <= '0;
      pcm_right <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete_c) begin
        if (!pcm_valid || pcm_ready) begin
          pcm_valid <= 1'b1;
          pcm_left  <= acc_l;
          pcm_right <= sum_r_c;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule
